// File: rtl/crc_pkg.sv
// Shared types and bit-level helpers for the stream CRC engine and its
// combinational update network.
package crc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [31:0] CRC8_POLY        = 32'h0000_0007;
    localparam logic [31:0] CRC16_CCITT_POLY = 32'h0000_1021;
    localparam logic [31:0] CRC32_POLY       = 32'h04C1_1DB7;

    // Reverse the low w bits of v; bits at w and above come back as zero.
    function automatic logic [63:0] bitrev(input logic [63:0] v, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            r[i] = v[w-1-i];
        end
        return r;
    endfunction

    // One bit of the serial LFSR, computed on a 32-bit carrier and masked to w bits.
    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic d,
                                             input logic [31:0] poly, input int w);
        logic        fb;
        logic [31:0] mask;
        fb   = crc[w-1] ^ d;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return ((crc << 1) ^ (fb ? poly : 32'd0)) & mask;
    endfunction

endpackage

// File: rtl/crc_comb_update.sv
// Purely combinational DATA_W-bit CRC update: a chain of DATA_W single-bit
// LFSR steps, fed MSB first or LSB first.
module crc_comb_update #(
    parameter int          CRC_W      = 8,
    parameter logic [31:0] POLY       = 32'h07,
    parameter int          DATA_W     = 8,
    parameter bit          REFLECT_IN = 1'b0
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [CRC_W-1:0]  crc_out
);
    import crc_pkg::*;

    logic [31:0] stage [0:DATA_W];

    assign stage[0] = 32'(crc_in);

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
        localparam int BIT_IDX = REFLECT_IN ? gi : (DATA_W - 1 - gi);
        assign stage[gi+1] = crc_step(stage[gi], data_in[BIT_IDX], POLY, CRC_W);
    end

    assign crc_out = stage[DATA_W][CRC_W-1:0];

endmodule

// File: rtl/crc_stream_engine.sv
// Frame-aware CRC generator/checker with valid/ready on the beat input and a
// single-entry registered result output.
module crc_stream_engine #(
    parameter int               CRC_W         = 8,
    parameter logic [CRC_W-1:0] POLY          = 'h07,
    parameter int               DATA_W        = 8,
    parameter logic [CRC_W-1:0] INIT          = 'h00,
    parameter logic [CRC_W-1:0] XOR_OUT       = 'h00,
    parameter bit               REFLECT_IN    = 1'b0,
    parameter bit               REFLECT_OUT   = 1'b0,
    parameter logic [CRC_W-1:0] CHECK_RESIDUE = 'h00,
    parameter int               LEN_W         = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    input  logic              check_mode,
    output logic [CRC_W-1:0]  res_crc,
    output logic              res_ok,
    output logic [LEN_W-1:0]  res_len,
    output logic              res_valid,
    input  logic              res_ready
);
    import crc_pkg::*;

    state_t             state_q, state_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               chk_q, chk_d;
    logic               res_valid_q, res_valid_d;
    logic [CRC_W-1:0]   res_crc_q, res_crc_d;
    logic               res_ok_q, res_ok_d;
    logic [LEN_W-1:0]   res_len_q, res_len_d;

    logic [CRC_W-1:0]   next_crc;
    logic [LEN_W-1:0]   cnt_inc;
    logic               accept;
    logic               chk_cur;

    crc_comb_update #(
        .CRC_W      (CRC_W),
        .POLY       (32'(POLY)),
        .DATA_W     (DATA_W),
        .REFLECT_IN (REFLECT_IN)
    ) u_update (
        .crc_in  (crc_q),
        .data_in (s_data),
        .crc_out (next_crc)
    );

    assign s_ready = !res_valid_q || res_ready;
    assign accept  = s_valid && s_ready;
    assign cnt_inc = (cnt_q == {LEN_W{1'b1}}) ? cnt_q : cnt_q + LEN_W'(1);
    // check_mode only matters on the first beat; later beats use the latched copy.
    assign chk_cur = (state_q == IDLE) ? check_mode : chk_q;

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        chk_d       = chk_q;
        res_valid_d = res_valid_q && !res_ready;
        res_crc_d   = res_crc_q;
        res_ok_d    = res_ok_q;
        res_len_d   = res_len_q;
        if (accept) begin
            if (s_last) begin
                res_valid_d = 1'b1;
                res_crc_d   = XOR_OUT ^ (REFLECT_OUT ? CRC_W'(bitrev(64'(next_crc), CRC_W))
                                                     : next_crc);
                res_ok_d    = chk_cur && (next_crc == CHECK_RESIDUE);
                res_len_d   = cnt_inc;
                crc_d       = INIT;
                cnt_d       = '0;
                state_d     = IDLE;
            end else begin
                crc_d   = next_crc;
                cnt_d   = cnt_inc;
                chk_d   = chk_cur;
                state_d = BUSY;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            crc_q       <= INIT;
            cnt_q       <= '0;
            chk_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_crc_q   <= '0;
            res_ok_q    <= 1'b0;
            res_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            chk_q       <= chk_d;
            res_valid_q <= res_valid_d;
            res_crc_q   <= res_crc_d;
            res_ok_q    <= res_ok_d;
            res_len_q   <= res_len_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_crc   = res_crc_q;
    assign res_ok    = res_ok_q;
    assign res_len   = res_len_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: three instances (CRC-8 default, reflected CRC-32,
// 2-bit length counter) share one input stream; CRC-8 is checked against a
// polynomial long-division model.
module tb_crc_stream_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_valid, s_last, check_mode, res_ready;

    logic        s_ready, res_ok, res_valid;
    logic [7:0]  res_crc;
    logic [15:0] res_len;

    logic        s_ready32, res_ok32, res_valid32;
    logic [31:0] res_crc32;
    logic [15:0] res_len32;

    logic        s_ready2, res_ok2, res_valid2;
    logic [7:0]  res_crc2;
    logic [1:0]  res_len2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    crc_stream_engine dut (
        .clock(clock), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .check_mode(check_mode), .res_crc(res_crc), .res_ok(res_ok),
        .res_len(res_len), .res_valid(res_valid), .res_ready(res_ready)
    );

    crc_stream_engine #(
        .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOR_OUT(32'hFFFFFFFF),
        .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1), .CHECK_RESIDUE(32'h0)
    ) dut32 (
        .clock(clock), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready32), .check_mode(check_mode), .res_crc(res_crc32), .res_ok(res_ok32),
        .res_len(res_len32), .res_valid(res_valid32), .res_ready(res_ready)
    );

    crc_stream_engine #(.LEN_W(2)) dut2 (
        .clock(clock), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready2), .check_mode(check_mode), .res_crc(res_crc2), .res_ok(res_ok2),
        .res_len(res_len2), .res_valid(res_valid2), .res_ready(res_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // CRC-8 (x^8+x^2+x+1, init 0) as the remainder of M(x)*x^8 divided by the generator.
    function automatic logic [7:0] ref_crc8(input byte unsigned msg[$]);
        bit         q[$];
        logic [8:0] gen;
        logic [7:0] r;
        gen = 9'h107;
        foreach (msg[i]) for (int b = 7; b >= 0; b--) q.push_back(msg[i][b]);
        for (int k = 0; k < 8; k++) q.push_back(1'b0);
        for (int i = 0; i + 8 < q.size(); i++) begin
            if (q[i]) for (int k = 0; k <= 8; k++) q[i+k] ^= gen[8-k];
        end
        for (int k = 0; k < 8; k++) r[7-k] = q[q.size()-8+k];
        return r;
    endfunction

    // Called at a negedge; presents one beat, waits (bounded) for acceptance,
    // and returns at the negedge following the accepting edge.
    task automatic beat(input logic [7:0] d, input logic last, input logic mode);
        int guard = 0;
        s_data = d; s_valid = 1'b1; s_last = last; check_mode = mode;
        #1;
        while (!s_ready && guard < 50) begin
            @(negedge clock); #1; guard++;
        end
        if (!s_ready) check("beat_accept_timeout", 32'd0, 32'd1);
        @(posedge clock);
        @(negedge clock);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    typedef struct {
        string       name;
        int          n;
        logic [7:0]  b [10];
        logic        mode;
        logic [7:0]  crc;
        logic        ok;
        logic [15:0] len;
    } vec_t;

    typedef struct {
        logic [7:0]  crc;
        logic        ok;
        int          n;
    } res_t;

    vec_t vecs [5];
    res_t expq [$];

    task automatic monitor();
        res_t e;
        int   sat;
        if (res_valid && res_ready) begin
            if (expq.size() == 0) begin
                check("rand_unexpected_result", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                sat = (e.n > 3) ? 3 : e.n;
                check("rand_crc", 32'(res_crc), 32'(e.crc));
                check("rand_ok", 32'(res_ok), 32'(e.ok));
                check("rand_len", 32'(res_len), 32'(e.n));
                check("rand_len_sat", 32'(res_len2), 32'(sat));
            end
        end
    endtask

    initial begin
        byte unsigned frm[$];
        logic         mode;
        res_t         e;
        int           cyc;

        reset = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        check_mode = 1'b0; res_ready = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset_s_ready", 32'(s_ready), 32'd1);
        check("reset_res_valid", 32'(res_valid), 32'd0);
        check("reset_res_crc", 32'(res_crc), 32'd0);
        check("reset_res_ok", 32'(res_ok), 32'd0);
        check("reset_res_len", 32'(res_len), 32'd0);
        @(negedge clock);

        for (int v = 0; v < 5; v++) for (int i = 0; i < 10; i++) vecs[v].b[i] = 8'h31 + 8'(i);
        vecs[0].name = "gen_123456789"; vecs[0].n = 9;  vecs[0].mode = 1'b0;
        vecs[0].crc = 8'hF4; vecs[0].ok = 1'b0; vecs[0].len = 16'd9;
        vecs[1].name = "gen_single_01"; vecs[1].n = 1;  vecs[1].mode = 1'b0; vecs[1].b[0] = 8'h01;
        vecs[1].crc = 8'h07; vecs[1].ok = 1'b0; vecs[1].len = 16'd1;
        vecs[2].name = "gen_single_00"; vecs[2].n = 1;  vecs[2].mode = 1'b0; vecs[2].b[0] = 8'h00;
        vecs[2].crc = 8'h00; vecs[2].ok = 1'b0; vecs[2].len = 16'd1;
        vecs[3].name = "chk_good";      vecs[3].n = 10; vecs[3].mode = 1'b1; vecs[3].b[9] = 8'hF4;
        vecs[3].crc = 8'h00; vecs[3].ok = 1'b1; vecs[3].len = 16'd10;
        vecs[4].name = "chk_bad";       vecs[4].n = 10; vecs[4].mode = 1'b1; vecs[4].b[9] = 8'hF5;
        vecs[4].crc = 8'h07; vecs[4].ok = 1'b0; vecs[4].len = 16'd10;

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                beat(vecs[v].b[i], i == vecs[v].n - 1, vecs[v].mode);
                if (i == vecs[v].n - 2) begin
                    #1; check({vecs[v].name, "_early_valid"}, 32'(res_valid), 32'd0);
                end
            end
            #1;
            check({vecs[v].name, "_valid"}, 32'(res_valid), 32'd1);
            check({vecs[v].name, "_crc"}, 32'(res_crc), 32'(vecs[v].crc));
            check({vecs[v].name, "_ok"}, 32'(res_ok), 32'(vecs[v].ok));
            check({vecs[v].name, "_len"}, 32'(res_len), 32'(vecs[v].len));
            if (v == 0) check("crc32_123456789", res_crc32, 32'hCBF43926);
            $display("[TB] vector %s crc=0x%0h ok=%0d len=%0d", vecs[v].name, res_crc, res_ok, res_len);
            @(negedge clock);
        end

        // Back-pressure: result A held while frame B waits, then both move on one edge.
        res_ready = 1'b0;
        beat(8'h01, 1'b1, 1'b0);
        s_data = 8'h00; s_valid = 1'b1; s_last = 1'b1; check_mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_s_ready_low", 32'(s_ready), 32'd0);
            check("bp_crc_stable", 32'(res_crc), 32'h07);
            check("bp_len_stable", 32'(res_len), 32'd1);
            @(negedge clock);
        end
        res_ready = 1'b1;
        #1;
        check("bp_s_ready_high", 32'(s_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        s_valid = 1'b0; s_last = 1'b0;
        #1;
        check("bp_second_valid", 32'(res_valid), 32'd1);
        check("bp_second_crc", 32'(res_crc), 32'h00);
        @(negedge clock);
        #1;
        check("bp_drained", 32'(res_valid), 32'd0);
        $display("[TB] backpressure sequence done");

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 4; i++) beat(8'hA5 + 8'(i), 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("midreset_valid", 32'(res_valid), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            beat(8'h31 + 8'(i), i == 8, 1'b0);
            if (i == 7) begin
                #1; check("midreset_no_spurious", 32'(res_valid), 32'd0);
            end
        end
        #1;
        check("midreset_crc", 32'(res_crc), 32'hF4);
        check("midreset_len", 32'(res_len), 32'd9);
        @(negedge clock);

        // Saturating length on the LEN_W=2 instance.
        for (int i = 0; i < 5; i++) beat(8'h11, i == 4, 1'b0);
        #1;
        check("lensat_len2", 32'(res_len2), 32'd3);
        check("lensat_len16", 32'(res_len), 32'd5);
        $display("[TB] saturation len2=%0d len16=%0d", res_len2, res_len);
        @(negedge clock);
        #1;
        check("pre_random_idle", 32'(res_valid), 32'd0);
        @(negedge clock);

        // Randomised frames with idle beats and random result back-pressure.
        cyc = 0;
        for (int f = 0; f < 40; f++) begin
            int n;
            int bi;
            frm.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) frm.push_back(8'($urandom_range(0, 255)));
            mode = 1'($urandom_range(0, 1));
            if (mode && $urandom_range(0, 1) == 1) frm.push_back(ref_crc8(frm));
            bi = 0;
            while (bi < frm.size() && cyc < 5000) begin
                if ($urandom_range(0, 3) == 0) begin
                    s_valid = 1'b0; s_last = 1'b0;
                end else begin
                    s_valid = 1'b1;
                    s_data = frm[bi];
                    s_last = (bi == frm.size() - 1);
                    check_mode = (bi == 0) ? mode : 1'($urandom_range(0, 1));
                end
                res_ready = ($urandom_range(0, 2) != 0);
                #1;
                monitor();
                if (s_valid && s_ready) begin
                    if (bi == frm.size() - 1) begin
                        e.crc = ref_crc8(frm);
                        e.ok  = mode && (e.crc == 8'h00);
                        e.n   = frm.size();
                        expq.push_back(e);
                        $display("[TB] frame %0d len=%0d mode=%0d exp_crc=0x%0h", f, e.n, mode, e.crc);
                    end
                    bi++;
                end
                @(negedge clock);
                cyc++;
            end
        end
        if (cyc >= 5000) check("rand_cycle_budget", 32'd1, 32'd0);
        s_valid = 1'b0; s_last = 1'b0; res_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            monitor();
            @(negedge clock);
        end
        check("rand_all_results_seen", 32'(expq.size()), 32'd0);
        check("rand_final_idle", 32'(res_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
